// File: rtl/mux2_arbiter.sv
// Two-requester round-robin arbiter feeding a one-deep registered output stage; 1-cycle accept-to-output.
// Optional packet locking via `MUX2_ARB_LOCK_EN (adds a_last/b_last). Backpressure: readies drop while output is full and stalled.
module mux2_arbiter #(
  parameter int WIDTH    = 8,
  parameter int HOLD_MAX = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             a_valid,
  input  logic [WIDTH-1:0] a_data,
  output logic             a_ready,
  input  logic             b_valid,
  input  logic [WIDTH-1:0] b_data,
  output logic             b_ready,
  output logic             sel,
  output logic             y_valid,
  output logic [WIDTH-1:0] y_data,
  input  logic             y_ready,
  output logic             busy
`ifdef MUX2_ARB_LOCK_EN
  ,
  input  logic             a_last,
  input  logic             b_last
`endif
);

  typedef enum logic [1:0] {IDLE, GRANT_A, GRANT_B} state_t;

  localparam logic [7:0] HOLD = 8'(HOLD_MAX);

  state_t           state, state_nxt;
  logic             last_b;
  logic [7:0]       cnt, cnt_nxt;
  logic             space, acc_a, acc_b, acc, cnt_inc, hold;
  logic [WIDTH-1:0] grant_data;

`ifdef MUX2_ARB_LOCK_EN
  logic in_pkt, in_pkt_nxt, acc_last;
`endif

  always_comb begin
    space      = !y_valid || y_ready;
    a_ready    = (state == GRANT_A) && space;
    b_ready    = (state == GRANT_B) && space;
    acc_a      = a_valid && a_ready;
    acc_b      = b_valid && b_ready;
    acc        = acc_a || acc_b;
    grant_data = acc_b ? b_data : a_data;
`ifdef MUX2_ARB_LOCK_EN
    // Packet mode: count packets, and pin the grant while a packet is open.
    acc_last   = (acc_a && a_last) || (acc_b && b_last);
    in_pkt_nxt = acc ? !acc_last : in_pkt;
    cnt_inc    = acc_last;
    hold       = in_pkt_nxt;
`else
    cnt_inc    = acc;
    hold       = 1'b0;
`endif
    cnt_nxt    = (cnt_inc && cnt < HOLD) ? cnt + 8'd1 : cnt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (a_valid && b_valid) state_nxt = last_b ? GRANT_A : GRANT_B;
        else if (a_valid)       state_nxt = GRANT_A;
        else if (b_valid)       state_nxt = GRANT_B;
      end
      GRANT_A: begin
        if (!hold) begin
          if (!a_valid)                          state_nxt = b_valid ? GRANT_B : IDLE;
          else if (cnt_nxt == HOLD && b_valid)   state_nxt = GRANT_B;
        end
      end
      GRANT_B: begin
        if (!hold) begin
          if (!b_valid)                          state_nxt = a_valid ? GRANT_A : IDLE;
          else if (cnt_nxt == HOLD && a_valid)   state_nxt = GRANT_A;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      last_b  <= 1'b1;
      cnt     <= 8'd0;
      sel     <= 1'b0;
      y_valid <= 1'b0;
      y_data  <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= (state_nxt != state) ? 8'd0 : cnt_nxt;
      // sel tracks the grant and keeps its last value through IDLE.
      if (state_nxt == GRANT_A) begin
        last_b <= 1'b0;
        sel    <= 1'b0;
      end else if (state_nxt == GRANT_B) begin
        last_b <= 1'b1;
        sel    <= 1'b1;
      end
      if (acc) begin
        y_valid <= 1'b1;
        y_data  <= grant_data;
      end else if (y_ready) begin
        y_valid <= 1'b0;
      end
    end
  end

`ifdef MUX2_ARB_LOCK_EN
  always_ff @(posedge clk) begin
    if (!rst_n) in_pkt <= 1'b0;
    else        in_pkt <= in_pkt_nxt;
  end
`endif

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_mux2_arbiter.sv
// Bench for mux2_arbiter: directed vector table, hand sequences for reset/lock, random run vs. reference model.
module tb_mux2_arbiter;

  localparam int HOLD = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       a_valid, b_valid, y_ready;
  logic [7:0] a_data, b_data;
  logic       a_ready, b_ready, sel, y_valid, busy;
  logic [7:0] y_data;
`ifdef MUX2_ARB_LOCK_EN
  logic       a_last, b_last;
`endif

  int errors = 0;
  int checks = 0;

  mux2_arbiter #(.WIDTH(8), .HOLD_MAX(HOLD)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_valid(a_valid), .a_data(a_data), .a_ready(a_ready),
    .b_valid(b_valid), .b_data(b_data), .b_ready(b_ready),
    .sel(sel), .y_valid(y_valid), .y_data(y_data), .y_ready(y_ready),
    .busy(busy)
`ifdef MUX2_ARB_LOCK_EN
    , .a_last(a_last), .b_last(b_last)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       av; logic [7:0] ad;
    logic       bv; logic [7:0] bd;
    logic       yr;
    logic       ar, br, sel, yv;
    logic [7:0] yd;
    logic       busy;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0; a_valid = 0; b_valid = 0; a_data = 0; b_data = 0; y_ready = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Reference model: owner 0=none,1=A,2=B; run counts beats served in the current tenure.
  int         m_own, m_prev, m_run, m_nxt;
  logic       m_sel, m_yv;
  logic [7:0] m_yd;

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int na, gap, got_b;
    logic space, e_ar, e_br, take, mine, other;
    logic [7:0] tdat;

`ifdef MUX2_ARB_LOCK_EN
    a_last = 1'b1; b_last = 1'b1;
`endif
    //       av ad     bv bd     yr ar br sel yv yd     busy
    vecs.push_back('{1, 8'h11, 0, 8'h00, 1, 0, 0, 0, 0, 8'h00, 0});
    vecs.push_back('{1, 8'h11, 0, 8'h00, 1, 1, 0, 0, 0, 8'h00, 1});
    vecs.push_back('{1, 8'h22, 0, 8'h00, 1, 1, 0, 0, 1, 8'h11, 1});
    vecs.push_back('{1, 8'h33, 0, 8'h00, 1, 1, 0, 0, 1, 8'h22, 1});
    vecs.push_back('{0, 8'h00, 0, 8'h00, 1, 1, 0, 0, 1, 8'h33, 1});
    vecs.push_back('{0, 8'h00, 1, 8'hA1, 1, 0, 0, 0, 0, 8'h33, 0});
    vecs.push_back('{0, 8'h00, 1, 8'hA1, 1, 0, 1, 1, 0, 8'h33, 1});
    vecs.push_back('{0, 8'h00, 1, 8'hA2, 0, 0, 0, 1, 1, 8'hA1, 1});
    vecs.push_back('{0, 8'h00, 1, 8'hA2, 0, 0, 0, 1, 1, 8'hA1, 1});
    vecs.push_back('{0, 8'h00, 1, 8'hA2, 0, 0, 0, 1, 1, 8'hA1, 1});
    vecs.push_back('{0, 8'h00, 1, 8'hA2, 1, 0, 1, 1, 1, 8'hA1, 1});
    vecs.push_back('{0, 8'h00, 0, 8'h00, 1, 0, 1, 1, 1, 8'hA2, 1});
    vecs.push_back('{1, 8'hB1, 1, 8'hC1, 1, 0, 0, 1, 0, 8'hA2, 0});
    vecs.push_back('{1, 8'hB1, 1, 8'hC1, 1, 1, 0, 0, 0, 8'hA2, 1});
    vecs.push_back('{1, 8'hB2, 1, 8'hC1, 1, 1, 0, 0, 1, 8'hB1, 1});
    vecs.push_back('{1, 8'hB3, 1, 8'hC1, 1, 1, 0, 0, 1, 8'hB2, 1});
    vecs.push_back('{1, 8'hB4, 1, 8'hC1, 1, 1, 0, 0, 1, 8'hB3, 1});
    vecs.push_back('{1, 8'hB5, 1, 8'hC1, 1, 0, 1, 1, 1, 8'hB4, 1});
    vecs.push_back('{1, 8'hB5, 1, 8'hC2, 1, 0, 1, 1, 1, 8'hC1, 1});
    vecs.push_back('{1, 8'hB5, 1, 8'hC3, 1, 0, 1, 1, 1, 8'hC2, 1});
    vecs.push_back('{1, 8'hB5, 1, 8'hC4, 1, 0, 1, 1, 1, 8'hC3, 1});
    vecs.push_back('{1, 8'hB5, 1, 8'hC5, 1, 1, 0, 0, 1, 8'hC4, 1});
    vecs.push_back('{0, 8'h00, 0, 8'h00, 1, 1, 0, 0, 1, 8'hB5, 1});
    vecs.push_back('{1, 8'hD1, 1, 8'hE1, 1, 0, 0, 0, 0, 8'hB5, 0});
    vecs.push_back('{1, 8'hD1, 1, 8'hE1, 1, 0, 1, 1, 0, 8'hB5, 1});
    vecs.push_back('{0, 8'h00, 0, 8'h00, 0, 0, 0, 1, 1, 8'hE1, 1});
    vecs.push_back('{0, 8'h00, 0, 8'h00, 1, 0, 0, 1, 1, 8'hE1, 0});
    vecs.push_back('{0, 8'h00, 0, 8'h00, 1, 0, 0, 1, 0, 8'hE1, 0});

    // Reset held with both requesters valid.
    rst_n = 1'b0; a_valid = 1; b_valid = 1; a_data = 8'h5A; b_data = 8'hA5; y_ready = 1;
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    chk("rst_sel", sel, 0);
    chk("rst_yv", y_valid, 0);
    chk("rst_ar", a_ready, 0);
    chk("rst_br", b_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_yd", y_data, 0);
    rst_n = 1'b1;
    @(negedge clk); #1;
    chk("first_grant_ar", a_ready, 1);
    chk("first_grant_br", b_ready, 0);
    chk("first_grant_sel", sel, 0);

    // Directed table.
    do_reset();
    for (int i = 0; i < vecs.size(); i++) begin
      a_valid = vecs[i].av; a_data = vecs[i].ad;
      b_valid = vecs[i].bv; b_data = vecs[i].bd;
      y_ready = vecs[i].yr;
      #1;
      chk($sformatf("v%0d_ar", i), a_ready, vecs[i].ar);
      chk($sformatf("v%0d_br", i), b_ready, vecs[i].br);
      chk($sformatf("v%0d_sel", i), sel, vecs[i].sel);
      chk($sformatf("v%0d_yv", i), y_valid, vecs[i].yv);
      chk($sformatf("v%0d_yd", i), y_data, vecs[i].yd);
      chk($sformatf("v%0d_busy", i), busy, vecs[i].busy);
      @(negedge clk);
    end

`ifdef MUX2_ARB_LOCK_EN
    // Six-beat A packet must not be split by B despite HOLD.
    do_reset();
    na = 0; gap = 0; got_b = 0;
    for (int c = 0; c < 40 && got_b == 0; c++) begin
      a_valid = (na < 6); a_data = 8'h60 + 8'(na); a_last = (na == 5);
      b_valid = 1; b_data = 8'h99; b_last = 1; y_ready = 1;
      #1;
      if (b_ready) begin
        got_b = 1;
        chk("lock_a_beats_before_b", na, 6);
        chk("lock_sel_b", sel, 1);
      end else if (na > 0 && na < 6 && !(a_valid && a_ready)) begin
        gap++;
      end
      if (a_valid && a_ready) na++;
      @(negedge clk);
    end
    chk("lock_b_granted", got_b, 1);
    chk("lock_contiguous", gap, 0);
    a_last = 1; b_last = 1;
`endif

    // Randomized run against the model.
    do_reset();
    m_own = 0; m_prev = 2; m_run = 0; m_sel = 0; m_yv = 0; m_yd = 0;
    for (int c = 0; c < 2000; c++) begin
      a_valid = ($urandom_range(0, 3) != 0);
      b_valid = ($urandom_range(0, 3) != 0);
      a_data  = 8'($urandom);
      b_data  = 8'($urandom);
      y_ready = ($urandom_range(0, 3) != 0);
      #1;
      space = !m_yv || y_ready;
      e_ar  = (m_own == 1) && space;
      e_br  = (m_own == 2) && space;
      chk("rnd_ar", a_ready, e_ar);
      chk("rnd_br", b_ready, e_br);
      chk("rnd_sel", sel, m_sel);
      chk("rnd_yv", y_valid, m_yv);
      if (m_yv) chk("rnd_yd", y_data, m_yd);
      chk("rnd_busy", busy, m_own != 0);

      take  = (e_ar && a_valid) || (e_br && b_valid);
      tdat  = (m_own == 2) ? b_data : a_data;
      mine  = (m_own == 1) ? a_valid : b_valid;
      other = (m_own == 1) ? b_valid : a_valid;
      if (m_own == 0) begin
        if (a_valid && b_valid) m_nxt = (m_prev == 1) ? 2 : 1;
        else if (a_valid)       m_nxt = 1;
        else if (b_valid)       m_nxt = 2;
        else                    m_nxt = 0;
      end else if (!mine) begin
        m_nxt = other ? 3 - m_own : 0;
      end else if ((m_run + int'(take)) >= HOLD && other) begin
        m_nxt = 3 - m_own;
      end else begin
        m_nxt = m_own;
      end
      if (m_nxt != m_own) m_run = 0;
      else                m_run = m_run + int'(take);
      if (m_nxt != 0) begin
        m_prev = m_nxt;
        m_sel  = (m_nxt == 2);
      end
      if (take) begin
        m_yv = 1; m_yd = tdat;
      end else if (y_ready) begin
        m_yv = 0;
      end
      m_own = m_nxt;
      @(negedge clk);
    end

    // Reset in the middle of traffic drops the output beat and the grant.
    a_valid = 1; b_valid = 1; y_ready = 0; rst_n = 1'b0;
    @(negedge clk); #1;
    chk("midrst_yv", y_valid, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_yd", y_data, 0);
    chk("midrst_sel", sel, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
